// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: shares one memory port between fetch and data stages with a watchdog; define ARB_RR_EN for round-robin on collisions
module mem_port_arbiter #(
  parameter int AW = 32,
  parameter int DW = 32,
  parameter int TIMEOUT = 16,
  parameter int CW = 5
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          if_req,
  input  logic [AW-1:0] if_addr,
  output logic [DW-1:0] if_rdata,
  output logic          if_valid,
  input  logic          dm_req,
  input  logic          dm_we,
  input  logic [AW-1:0] dm_addr,
  input  logic [DW-1:0] dm_wdata,
  output logic [DW-1:0] dm_rdata,
  output logic          dm_valid,
  output logic          mem_en,
  output logic          mem_we,
  output logic [AW-1:0] mem_addr,
  output logic [DW-1:0] mem_wdata,
  input  logic [DW-1:0] mem_rdata,
  input  logic          mem_ack,
  output logic          stall_f,
  output logic          stall_m,
  output logic          err
);
  typedef enum logic [1:0] {IDLE, IF_BUSY, DM_BUSY} state_t;
  state_t state_q, state_d;
  logic [CW-1:0] wd_q, wd_d;
  logic mem_en_q, mem_en_d, mem_we_q, mem_we_d, err_q, err_d;
  logic if_valid_q, if_valid_d, dm_valid_q, dm_valid_d;
  logic [AW-1:0] mem_addr_q, mem_addr_d;
  logic [DW-1:0] mem_wdata_q, mem_wdata_d, if_rdata_q, if_rdata_d, dm_rdata_q, dm_rdata_d;
  logic pick_dm, busy, abort, done;
  logic [DW-1:0] rsp;
  assign stall_f = if_req & ~if_valid_q;
  assign stall_m = dm_req & ~dm_valid_q;
  assign if_rdata = if_rdata_q;
  assign if_valid = if_valid_q;
  assign dm_rdata = dm_rdata_q;
  assign dm_valid = dm_valid_q;
  assign mem_en = mem_en_q;
  assign mem_we = mem_we_q;
  assign mem_addr = mem_addr_q;
  assign mem_wdata = mem_wdata_q;
  assign err = err_q;
`ifdef ARB_RR_EN
  logic last_dm_q, last_dm_d;
  assign pick_dm = stall_m & (~stall_f | ~last_dm_q);
  assign last_dm_d = (state_q == IDLE && (stall_f || stall_m)) ? pick_dm : last_dm_q;
  always_ff @(posedge clk) last_dm_q <= !rst ? 1'b0 : last_dm_d;
`else
  assign pick_dm = stall_m;
`endif
  assign busy = state_q != IDLE;
  assign abort = busy & ~mem_ack & (wd_q == CW'(TIMEOUT - 1));
  assign done = busy & (mem_ack | abort);
  assign rsp = abort ? '0 : mem_rdata;
  always_comb begin
    state_d = state_q;
    wd_d = wd_q;
    mem_en_d = mem_en_q;
    mem_we_d = mem_we_q;
    mem_addr_d = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    err_d = err_q;
    if_valid_d = 1'b0;
    dm_valid_d = 1'b0;
    if_rdata_d = if_rdata_q;
    dm_rdata_d = dm_rdata_q;
    if (!busy && (stall_f || stall_m)) begin
      state_d = pick_dm ? DM_BUSY : IF_BUSY;
      mem_en_d = 1'b1;
      mem_we_d = pick_dm & dm_we;
      mem_addr_d = pick_dm ? dm_addr : if_addr;
      mem_wdata_d = pick_dm ? dm_wdata : '0;
    end else if (done) begin
      state_d = IDLE;
      mem_en_d = 1'b0;
      wd_d = '0;
      err_d = err_q | abort;
      if_valid_d = state_q == IF_BUSY;
      dm_valid_d = state_q == DM_BUSY;
      if_rdata_d = (state_q == IF_BUSY) ? rsp : if_rdata_q;
      dm_rdata_d = (state_q == DM_BUSY && (abort || !mem_we_q)) ? rsp : dm_rdata_q;
    end else if (busy) begin
      wd_d = wd_q + CW'(1);
    end
  end
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q <= IDLE;
      wd_q <= '0;
      mem_en_q <= 1'b0;
      mem_we_q <= 1'b0;
      mem_addr_q <= '0;
      mem_wdata_q <= '0;
      err_q <= 1'b0;
      if_valid_q <= 1'b0;
      dm_valid_q <= 1'b0;
      if_rdata_q <= '0;
      dm_rdata_q <= '0;
    end else begin
      state_q <= state_d;
      wd_q <= wd_d;
      mem_en_q <= mem_en_d;
      mem_we_q <= mem_we_d;
      mem_addr_q <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      err_q <= err_d;
      if_valid_q <= if_valid_d;
      dm_valid_q <= dm_valid_d;
      if_rdata_q <= if_rdata_d;
      dm_rdata_q <= dm_rdata_d;
    end
  end
endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb_mem_port_arbiter: directed vectors, corner sequences and randomized traffic against a transaction-level model
module tb_mem_port_arbiter;
  localparam int AW = 32, DW = 32, TO = 16, CW = 5;
  logic clk = 0, rst = 0;
  logic if_req = 0, dm_req = 0, dm_we = 0, mem_ack = 0;
  logic [31:0] if_addr = 0, dm_addr = 0, dm_wdata = 0, mem_rdata = 0;
  logic [31:0] if_rdata, dm_rdata, mem_addr, mem_wdata;
  logic if_valid, dm_valid, mem_en, mem_we, stall_f, stall_m, err;
  int total = 0, bad = 0;
  always #5 clk = ~clk;
  mem_port_arbiter #(.AW(AW), .DW(DW), .TIMEOUT(TO), .CW(CW)) dut (
    .clk(clk), .rst(rst), .if_req(if_req), .if_addr(if_addr), .if_rdata(if_rdata),
    .if_valid(if_valid), .dm_req(dm_req), .dm_we(dm_we), .dm_addr(dm_addr),
    .dm_wdata(dm_wdata), .dm_rdata(dm_rdata), .dm_valid(dm_valid), .mem_en(mem_en),
    .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata),
    .mem_ack(mem_ack), .stall_f(stall_f), .stall_m(stall_m), .err(err)
  );
  typedef struct {
    bit dm;
    bit we;
    logic [31:0] addr, wdata, mrd, exp_rd;
    int lat, exp_cyc;
    bit exp_err;
  } vec_t;
  vec_t vecs[7];
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic run_txn(input vec_t v);
    int bi, cyc;
    bit seen;
    bi = 0; cyc = 0; seen = 0;
    if (v.dm) begin
      dm_req = 1; dm_we = v.we; dm_addr = v.addr; dm_wdata = v.wdata;
    end else begin
      if_req = 1; if_addr = v.addr;
    end
    #1 chk("stall_pending", 32'(v.dm ? stall_m : stall_f), 1);
    for (int c = 1; c <= 40 && cyc == 0; c++) begin
      tick();
      if (mem_en && !seen) begin
        seen = 1;
        chk("cmd_addr", mem_addr, v.addr);
        chk("cmd_we", 32'(mem_we), 32'(v.dm && v.we));
        if (v.we) chk("cmd_wdata", mem_wdata, v.wdata);
      end
      if (v.dm ? dm_valid : if_valid) begin
        cyc = c;
        mem_ack = 0;
      end else begin
        mem_ack = mem_en && bi == v.lat;
        mem_rdata = v.mrd;
        if (mem_en) bi++;
      end
    end
    mem_ack = 0;
    chk("latency", 32'(cyc), 32'(v.exp_cyc));
    chk("rdata", v.dm ? dm_rdata : if_rdata, v.exp_rd);
    chk("err", 32'(err), 32'(v.exp_err));
    chk("en_gap", 32'(mem_en), 0);
    chk("other_valid", 32'(v.dm ? if_valid : dm_valid), 0);
    if_req = 0; dm_req = 0; dm_we = 0;
    tick();
  endtask
  task automatic collision();
    bit first_dm;
`ifdef ARB_RR_EN
    first_dm = 0;
`else
    first_dm = 1;
`endif
    if_req = 1; if_addr = 32'h40;
    dm_req = 1; dm_we = 1; dm_addr = 32'h100; dm_wdata = 32'hA5A5A5A5;
    mem_rdata = 32'h0BADC0DE;
    tick(); mem_ack = mem_en;
    chk("col1_en", 32'(mem_en), 1);
    chk("col1_we", 32'(mem_we), 32'(first_dm));
    chk("col1_addr", mem_addr, first_dm ? 32'h100 : 32'h40);
    tick(); mem_ack = mem_en;
    chk("col1_valid", 32'(first_dm ? dm_valid : if_valid), 1);
    chk("col_gap", 32'(mem_en), 0);
    if (first_dm) dm_req = 0; else if_req = 0;
    tick(); mem_ack = mem_en;
    chk("col2_en", 32'(mem_en), 1);
    chk("col2_addr", mem_addr, first_dm ? 32'h40 : 32'h100);
    chk("col2_we", 32'(mem_we), 32'(!first_dm));
    tick(); mem_ack = 0;
    chk("col2_valid", 32'(first_dm ? if_valid : dm_valid), 1);
    chk("col_if_rdata", if_rdata, 32'h0BADC0DE);
    chk("col_dm_rdata", dm_rdata, 0);
    if_req = 0; dm_req = 0; dm_we = 0;
    tick();
  endtask
  task automatic mid_reset();
    if_req = 1; if_addr = 32'h80;
    tick();
    chk("rst_busy_en", 32'(mem_en), 1);
    tick();
    rst = 0; if_req = 0;
    tick();
    chk("rst_en", 32'(mem_en), 0);
    chk("rst_valid", 32'(if_valid), 0);
    chk("rst_err", 32'(err), 0);
    chk("rst_if_rdata", if_rdata, 0);
    rst = 1; mem_ack = 1; mem_rdata = 32'hFFFF0000;
    tick();
    chk("late_ack_valid", 32'(if_valid), 0);
    chk("late_ack_en", 32'(mem_en), 0);
    chk("late_ack_rdata", if_rdata, 0);
    mem_ack = 0;
  endtask
  task automatic drop_mid();
    dm_req = 1; dm_we = 0; dm_addr = 32'h500;
    tick();
    chk("drop_en", 32'(mem_en), 1);
    dm_req = 0;
    #1 chk("drop_stall", 32'(stall_m), 0);
    tick();
    chk("drop_still_busy", 32'(mem_en), 1);
    mem_ack = 1; mem_rdata = 32'h77;
    tick(); mem_ack = 0;
    chk("drop_valid", 32'(dm_valid), 1);
    chk("drop_rdata", dm_rdata, 32'h77);
    tick();
  endtask
  task automatic rand_test(input int n);
    bit pen, pack, pfp, pdp, owner, cwe, last_dm, ffin, dfin, efv, edv, een, done, ab, eerr;
    logic [31:0] pdata, caddr, cwd, efr, edr;
    int k, lat;
    rst = 0; if_req = 0; dm_req = 0; dm_we = 0; mem_ack = 0;
    tick(); tick();
    rst = 1;
    pen = 0; pack = 0; pfp = 0; pdp = 0; owner = 0; cwe = 0; last_dm = 0; ffin = 0; dfin = 0;
    eerr = 0; een = 0; pdata = 0; caddr = 0; cwd = 0; efr = 0; edr = 0; k = 0; lat = 0;
    for (int i = 0; i < n; i++) begin
      tick();
      efv = 0; edv = 0;
      if (pen) begin
        done = pack || k == TO - 1;
        een = !done;
        if (done) begin
          ab = !pack;
          if (owner) begin
            edv = 1;
            if (ab || !cwe) edr = ab ? 32'd0 : pdata;
          end else begin
            efv = 1;
            efr = ab ? 32'd0 : pdata;
          end
          if (ab) eerr = 1;
        end else k++;
      end else if (pfp || pdp) begin
        een = 1; k = 0;
`ifdef ARB_RR_EN
        owner = (pfp && pdp) ? !last_dm : pdp;
`else
        owner = pdp;
`endif
        last_dm = owner;
        cwe = owner && dm_we;
        caddr = owner ? dm_addr : if_addr;
        cwd = dm_wdata;
        lat = ($urandom_range(0, 9) == 0) ? int'($urandom_range(TO - 2, TO + 2)) : int'($urandom_range(0, 3));
      end else een = 0;
      chk("r_en", 32'(mem_en), 32'(een));
      if (een) begin
        chk("r_addr", mem_addr, caddr);
        chk("r_we", 32'(mem_we), 32'(cwe));
        if (cwe) chk("r_wdata", mem_wdata, cwd);
      end
      chk("r_if_valid", 32'(if_valid), 32'(efv));
      chk("r_dm_valid", 32'(dm_valid), 32'(edv));
      chk("r_if_rdata", if_rdata, efr);
      chk("r_dm_rdata", dm_rdata, edr);
      chk("r_err", 32'(err), 32'(eerr));
      if (efv) ffin = 1;
      else if (ffin || !if_req) begin
        ffin = 0;
        if_req = $urandom_range(0, 2) != 0;
        if_addr = {1'b0, 31'($urandom)};
      end
      if (edv) dfin = 1;
      else if (dfin || !dm_req) begin
        dfin = 0;
        dm_req = $urandom_range(0, 2) != 0;
        dm_we = $urandom_range(0, 1) != 0;
        dm_addr = {1'b1, 31'($urandom)};
        dm_wdata = $urandom;
      end
      mem_ack = een ? (k == lat) : ($urandom_range(0, 7) == 0);
      mem_rdata = $urandom;
      pen = een; pack = mem_ack; pdata = mem_rdata;
      pfp = if_req && !efv; pdp = dm_req && !edv;
      #3;
      chk("r_stall_f", 32'(stall_f), 32'(pfp));
      chk("r_stall_m", 32'(stall_m), 32'(pdp));
    end
    if_req = 0; dm_req = 0; mem_ack = 0;
  endtask
  initial begin
    vecs[0] = '{0, 0, 32'h40,  32'h0,        32'h00500093, 32'h00500093, 3,  5,  0};
    vecs[1] = '{1, 0, 32'h200, 32'h0,        32'hCAFEF00D, 32'hCAFEF00D, 0,  2,  0};
    vecs[2] = '{1, 1, 32'h100, 32'hA5A5A5A5, 32'hDEADBEEF, 32'hCAFEF00D, 1,  3,  0};
    vecs[3] = '{0, 0, 32'h44,  32'h0,        32'h12345678, 32'h12345678, 15, 17, 0};
    vecs[4] = '{1, 0, 32'h300, 32'h0,        32'h55555555, 32'h0,        99, 17, 1};
    vecs[5] = '{0, 0, 32'h48,  32'h0,        32'h11111111, 32'h11111111, 2,  4,  1};
    vecs[6] = '{1, 1, 32'h104, 32'h3C3C3C3C, 32'h99999999, 32'h0,        0,  2,  1};
    tick(); tick();
    chk("reset_en", 32'(mem_en), 0);
    chk("reset_we", 32'(mem_we), 0);
    chk("reset_addr", mem_addr, 0);
    chk("reset_wdata", mem_wdata, 0);
    chk("reset_if_valid", 32'(if_valid), 0);
    chk("reset_dm_valid", 32'(dm_valid), 0);
    chk("reset_if_rdata", if_rdata, 0);
    chk("reset_dm_rdata", dm_rdata, 0);
    chk("reset_err", 32'(err), 0);
    rst = 1;
    tick();
    for (int i = 0; i < 7; i++) run_txn(vecs[i]);
    collision();
    mid_reset();
    drop_mid();
    rand_test(3000);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
- Sequences the single shared memory port between the fetch stage (instruction reads) and the memory stage (data reads/writes) of the pipelined core.
- Grants one requester at a time and holds the command stable until the memory acknowledges.
- Returns read data with a one-cycle valid pulse, and drives per-stage stall outputs into the pipeline stall network.
- Includes a watchdog that aborts transactions the memory never acknowledges.

Parameters:
- AW, 32, address width in bits.
- DW, 32, data width in bits.
- TIMEOUT, 16, maximum busy cycles before abort; must be ≥2.
- CW, 5, watchdog counter width; requires 2^CW > TIMEOUT.

Ports:
- clk  in  1  rising-edge clock.
- rst  in  1  synchronous reset, active-low: state clears on the clk edge where rst==0.
- if_req  in  1  fetch read request; held high until if_valid.
- if_addr  in  AW  fetch address.
- if_rdata  out  DW  fetched instruction, valid when if_valid==1.
- if_valid  out  1  one-cycle completion pulse for fetch.
- dm_req  in  1  data request; held high until dm_valid.
- dm_we  in  1  1 = write, 0 = read.
- dm_addr  in  AW  data address.
- dm_wdata  in  DW  write data.
- dm_rdata  out  DW  read data, valid when dm_valid==1.
- dm_valid  out  1  one-cycle completion pulse for data (reads and writes).
- mem_en  out  1  command active; held for the whole transaction.
- mem_we  out  1  write strobe qualified by mem_en.
- mem_addr  out  AW  registered command address.
- mem_wdata  out  DW  registered write data.
- mem_rdata  in  DW  memory read data, sampled with mem_ack.
- mem_ack  in  1  single-cycle completion from memory.
- stall_f  out  1  = if_req & ~if_valid (combinational).
- stall_m  out  1  = dm_req & ~dm_valid (combinational).
- err  out  1  sticky timeout flag.

Behaviour:
- **Reset values:** all registered outputs are 0; state = IDLE; watchdog = 0; err = 0; last-grant = IF.
- **States:** IDLE, IF_BUSY, DM_BUSY.
- **IDLE:**
  - dm_req → DM_BUSY; else if_req → IF_BUSY.
  - Both requesting → DM wins, since it is the older instruction (fixed priority).
  - On entry, register mem_addr, mem_we (dm_we for DM, 0 for IF) and mem_wdata, and set mem_en=1 in the next cycle.
- **BUSY:**
  - mem_en and the command registers are frozen; the watchdog increments each cycle.
  - mem_ack is accepted only in BUSY states; an ack in IDLE is ignored.
  - On mem_ack, capture mem_rdata into the granted requester's rdata register and pulse its valid for one cycle.
  - In the same edge: mem_en=0, watchdog=0, state → IDLE.
- **Timing:**
  - Minimum latency from req rise to valid is 2 cycles: grant edge, then ack on the first mem_en cycle.
  - One idle cycle separates back-to-back transactions, so mem_en drops for ≥1 cycle between commands.
- **Write completion:** dm_rdata is unchanged; dm_valid still pulses.
- **Watchdog:**
  - When the counter reaches TIMEOUT-1 with no ack, abort: pulse the granted valid, force its rdata to 0, set err=1 (sticky until reset), drop mem_en, go to IDLE.
  - An ack arriving in the abort cycle takes precedence: normal completion, err unchanged.
- **Mid-transaction changes:**
  - A requester dropping req mid-transaction does not cancel the transaction; the valid pulse is still issued.
  - Request changes while busy are not sampled until IDLE.
- **Reset mid-transaction:** return to IDLE, mem_en=0, no valid pulse.
- **Data retention:** rdata registers hold their value between transactions.

Optional Feature:
- Macro: ARB_RR_EN.
- Defined: when both requesters are pending in IDLE, grant the one not granted last (last-grant register updated on every grant). Single requests are unaffected.
- Undefined: fixed DM-over-IF priority; the last-grant register is not implemented.

Test Plan:
- Single fetch: if_req=1, if_addr=0x40; memory acks 3 cycles after mem_en with 0x00500093 → mem_addr=0x40, mem_we=0, if_rdata=0x00500093, if_valid one cycle, stall_f high until then.
- Collision: if_req and dm_req rise together, dm_we=1, dm_addr=0x100, dm_wdata=0xA5A5A5A5 → DM write issued first (mem_we=1), dm_valid pulses; after ≥1 mem_en-low cycle, fetch issued.
- Same collision with ARB_RR_EN, last-grant = DM → fetch served first.
- Timeout: dm_req read, mem_ack held 0 → after TIMEOUT=16 busy cycles dm_valid pulses, dm_rdata=0, err=1, which stays 1 through later good transactions.
- Reset mid-transaction: rst=0 during IF_BUSY → mem_en=0 next edge, no if_valid; an ack arriving afterwards is ignored.
- Ack at the abort edge (cycle TIMEOUT-1) with data 0x12345678 → normal completion, rdata=0x12345678, err stays 0.
